// File: rtl/kronos_div.sv
// kronos_div: iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU).
// Define KRONOS_DIV_REM_FUSE_EN to reuse the last result for a matching request.
module kronos_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [1:0]  divop,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, dvs, mag1, mag2, rem_nx, quo_nx, q_fin, r_fin, hit_res;
  logic [32:0] diff;
  logic        sel_rem, qs, rs, sgn, accept, div0, ovf, special, hit, last;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign sgn     = ~divop[0];
  assign accept  = in_valid && in_ready && !flush;
  assign div0    = op2 == 32'd0;
  assign ovf     = sgn && op1 == 32'h8000_0000 && op2 == 32'hffff_ffff;
  assign special = div0 || ovf;
  assign mag1    = sgn && op1[31] ? -op1 : op1;
  assign mag2    = sgn && op2[31] ? -op2 : op2;
  assign last    = state == CALC && cnt == 5'd31;
  // bit 32 of the trial difference is the borrow: set only when the shifted remainder < divisor
  assign diff    = {rem, quo[31]} - {1'b0, dvs};
  assign rem_nx  = diff[32] ? {rem[30:0], quo[31]} : diff[31:0];
  assign quo_nx  = {quo[30:0], ~diff[32]};
  assign q_fin   = qs ? -quo_nx : quo_nx;
  assign r_fin   = rs ? -rem_nx : rem_nx;
`ifdef KRONOS_DIV_REM_FUSE_EN
  logic [31:0] tag1, tag2, c_quo, c_rem;
  logic        tag_uns, tag_vld;
  assign hit     = tag_vld && tag1 == op1 && tag2 == op2 && tag_uns == divop[0];
  assign hit_res = divop[1] ? c_rem : c_quo;
  // the tag is rewritten at accept and only marked valid once its result exists
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag1 <= '0; tag2 <= '0; tag_uns <= 1'b0; tag_vld <= 1'b0; c_quo <= '0; c_rem <= '0;
    end else if (flush) begin
      tag_vld <= 1'b0;
    end else if (accept && (special || !hit)) begin
      tag1    <= op1;
      tag2    <= op2;
      tag_uns <= divop[0];
      tag_vld <= special;
      c_quo   <= div0 ? 32'hffff_ffff : 32'h8000_0000;
      c_rem   <= div0 ? op1 : 32'd0;
    end else if (last) begin
      tag_vld <= 1'b1;
      c_quo   <= q_fin;
      c_rem   <= r_fin;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = accept ? ((special || hit) ? DONE : CALC) : IDLE;
      CALC: state_nx = last ? DONE : CALC;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; rem <= '0; quo <= '0; dvs <= '0; sel_rem <= 1'b0; qs <= 1'b0; rs <= 1'b0; result <= '0;
    end else if (accept) begin
      sel_rem <= divop[1];
      qs      <= sgn && (op1[31] ^ op2[31]);
      rs      <= sgn && op1[31];
      dvs     <= mag2;
      quo     <= mag1;
      rem     <= '0;
      cnt     <= '0;
      if (special) result <= divop[1] ? (div0 ? op1 : 32'd0) : (div0 ? 32'hffff_ffff : 32'h8000_0000);
      else if (hit) result <= hit_res;
    end else if (state == CALC && !flush) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 5'd1;
      if (last) result <= sel_rem ? r_fin : q_fin;
    end
  end
endmodule
